// File: rtl/frame_loader_pkg.sv
// Shared types and default sizing for the double-buffered frame loader.
package frame_loader_pkg;

  localparam int DEF_SPI_WIDTH    = 8;
  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_N            = 9;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } wr_state_e;

endpackage

// File: rtl/frame_loader_sample_assembler.sv
// Packs consecutive SPI words MSB-first into one sample; a partial sample
// waits through idle cycles until its remaining words arrive.
module sample_assembler
  import frame_loader_pkg::*;
#(
  parameter int SPI_WIDTH    = DEF_SPI_WIDTH,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
) (
  input  logic                    sclk,
  input  logic                    reset,
  input  logic                    received_wd,
  input  logic [SPI_WIDTH-1:0]    sample_in,
  output logic                    sample_valid,
  output logic [SAMPLE_WIDTH-1:0] sample
);

  localparam int WORDS = SAMPLE_WIDTH / SPI_WIDTH;
  localparam logic [2:0] LAST = 3'(WORDS - 1);

  logic [2:0]              count_q, count_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    valid_q, valid_d;

  always_comb begin
    count_d = count_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    if (received_wd) begin
      shift_d = SAMPLE_WIDTH'({shift_q, sample_in});
      if (count_q == LAST) begin
        count_d = 3'd0;
        valid_d = 1'b1;
      end else begin
        count_d = count_q + 3'd1;
      end
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      count_q <= 3'd0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  // The shift register holds exactly the finished sample during the valid cycle.
  assign sample_valid = valid_q;
  assign sample       = shift_q;

endmodule

// File: rtl/frame_loader.sv
// Ping-pong frame buffer: SPI samples fill one bank while the consumer
// reads the other; full frames swap banks or stall in HOLD and drop samples.
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int SPI_WIDTH    = DEF_SPI_WIDTH,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int N            = DEF_N
) (
  input  logic                    sclk,
  input  logic                    reset,
  input  logic                    received_wd,
  input  logic [SPI_WIDTH-1:0]    sample_in,
  input  logic                    rd_en,
  input  logic [N-1:0]            rd_addr,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    frame_ready,
  output logic                    frame_bank,
  input  logic                    frame_done,
  output logic                    overflow,
  output logic [N:0]              wr_count
);

  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] sample;

  sample_assembler #(
    .SPI_WIDTH   (SPI_WIDTH),
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_assembler (
    .sclk        (sclk),
    .reset       (reset),
    .received_wd (received_wd),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample      (sample)
  );

  wr_state_e               state_q, state_d;
  logic                    fill_bank_q, fill_bank_d;
  logic [N-1:0]            wr_ptr_q, wr_ptr_d;
  logic [N:0]              wr_count_q, wr_count_d;
  logic                    ready_q, ready_d;
  logic                    bank_q, bank_d;
  logic                    overflow_q, overflow_d;
  logic [SAMPLE_WIDTH-1:0] rd_data_q;
  logic                    wr_en;
  logic                    swap;
  logic                    done_valid;

  logic [SAMPLE_WIDTH-1:0] mem [0:(2**(N+1))-1];

  // A release only counts while a frame is actually outstanding.
  assign done_valid = frame_done & ready_q;

  always_comb begin
    state_d     = state_q;
    fill_bank_d = fill_bank_q;
    wr_ptr_d    = wr_ptr_q;
    wr_count_d  = wr_count_q;
    ready_d     = ready_q & ~done_valid;
    bank_d      = bank_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;
    swap        = 1'b0;
    unique case (state_q)
      FILL: begin
        if (sample_valid) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + N'(1);
          wr_count_d = wr_count_q + (N+1)'(1);
          if (&wr_ptr_q) begin
            if (!ready_q || done_valid) swap = 1'b1;
            else state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (sample_valid) overflow_d = 1'b1;
        if (done_valid) begin
          swap    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (swap) begin
      ready_d     = 1'b1;
      bank_d      = fill_bank_q;
      fill_bank_d = ~fill_bank_q;
      wr_ptr_d    = '0;
      wr_count_d  = '0;
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      fill_bank_q <= 1'b0;
      wr_ptr_q    <= '0;
      wr_count_q  <= '0;
      ready_q     <= 1'b0;
      bank_q      <= 1'b0;
      overflow_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_bank_q <= fill_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_count_q  <= wr_count_d;
      ready_q     <= ready_d;
      bank_q      <= bank_d;
      overflow_q  <= overflow_d;
      if (rd_en) rd_data_q <= mem[{bank_q, rd_addr}];
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge sclk) begin
    if (wr_en) mem[{fill_bank_q, wr_ptr_q}] <= sample;
  end

  assign rd_data     = rd_data_q;
  assign frame_ready = ready_q;
  assign frame_bank  = bank_q;
  assign overflow    = overflow_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader with N=3, 8-bit words, 16-bit samples.
module tb_frame_loader;

  localparam int N = 3;

  logic        sclk        = 1'b0;
  logic        reset       = 1'b1;
  logic        received_wd = 1'b0;
  logic [7:0]  sample_in   = 8'h00;
  logic        rd_en       = 1'b0;
  logic [N-1:0] rd_addr    = '0;
  logic        frame_done  = 1'b0;
  logic [15:0] rd_data;
  logic        frame_ready;
  logic        frame_bank;
  logic        overflow;
  logic [N:0]  wr_count;

  int checkCount = 0;
  int passCount  = 0;

  logic [15:0] expQ [$];

  typedef struct {
    logic [N-1:0] addr;
    logic [15:0]  expData;
  } readVec_t;

  readVec_t frame0Vec [8];

  frame_loader #(
    .SPI_WIDTH   (8),
    .SAMPLE_WIDTH(16),
    .N           (N)
  ) dut (
    .sclk       (sclk),
    .reset      (reset),
    .received_wd(received_wd),
    .sample_in  (sample_in),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_ready(frame_ready),
    .frame_bank (frame_bank),
    .frame_done (frame_done),
    .overflow   (overflow),
    .wr_count   (wr_count)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(negedge sclk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    received_wd = 1'b1;
    sample_in   = w;
    tick();
    received_wd = 1'b0;
  endtask

  task automatic sendWords(input int first, input int count);
    for (int i = 0; i < count; i++) applyStimulus(8'(first + i));
  endtask

  task automatic readCheck(input string name, input logic [N-1:0] a, input logic [15:0] e);
    logic [15:0] exp;
    rd_en   = 1'b1;
    rd_addr = a;
    expQ.push_back(e);
    tick();
    rd_en = 1'b0;
    exp = expQ.pop_front();
    checkOutput(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic strobeDone();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame0Vec[0] = '{3'd5, 16'h0A0B};
    frame0Vec[1] = '{3'd0, 16'h0001};
    frame0Vec[2] = '{3'd1, 16'h0203};
    frame0Vec[3] = '{3'd2, 16'h0405};
    frame0Vec[4] = '{3'd3, 16'h0607};
    frame0Vec[5] = '{3'd4, 16'h0809};
    frame0Vec[6] = '{3'd6, 16'h0C0D};
    frame0Vec[7] = '{3'd7, 16'h0E0F};

    tick();
    tick();
    checkOutput("reset frame_ready", 32'(frame_ready), 32'd0);
    checkOutput("reset frame_bank",  32'(frame_bank),  32'd0);
    checkOutput("reset overflow",    32'(overflow),    32'd0);
    checkOutput("reset wr_count",    32'(wr_count),    32'd0);
    checkOutput("reset rd_data",     32'(rd_data),     32'd0);
    reset = 1'b0;
    tick();

    // First frame, with idle gap mid-sample after word 0x04.
    sendWords(0, 5);
    tick();
    tick();
    tick();
    checkOutput("partial wr_count", 32'(wr_count), 32'd2);
    sendWords(5, 11);
    tick();
    checkOutput("frame0 frame_ready", 32'(frame_ready), 32'd1);
    checkOutput("frame0 frame_bank",  32'(frame_bank),  32'd0);
    checkOutput("frame0 wr_count",    32'(wr_count),    32'd0);
    checkOutput("frame0 overflow",    32'(overflow),    32'd0);

    for (int i = 0; i < 8; i++) readCheck("rd_data frame0", frame0Vec[i].addr, frame0Vec[i].expData);
    rd_addr = 3'd0;
    tick();
    checkOutput("rd_data hold", 32'(rd_data), 32'h0E0F);

    // Second frame with no release: enters HOLD, then third-frame samples drop.
    sendWords(16, 16);
    tick();
    checkOutput("hold frame_bank", 32'(frame_bank), 32'd0);
    checkOutput("hold frame_ready", 32'(frame_ready), 32'd1);
    checkOutput("hold overflow pre", 32'(overflow), 32'd0);
    checkOutput("hold wr_count", 32'(wr_count), 32'd8);
    sendWords(32, 4);
    tick();
    checkOutput("hold overflow", 32'(overflow), 32'd1);
    checkOutput("hold wr_count drop", 32'(wr_count), 32'd8);
    readCheck("rd_data bank0 kept", 3'd2, 16'h0405);
    strobeDone();
    checkOutput("hold release bank", 32'(frame_bank), 32'd1);
    checkOutput("hold release ready", 32'(frame_ready), 32'd1);
    checkOutput("hold release wr_count", 32'(wr_count), 32'd0);
    checkOutput("overflow sticky", 32'(overflow), 32'd1);
    readCheck("rd_data frame1 a3", 3'd3, 16'h1617);
    readCheck("rd_data frame1 a7", 3'd7, 16'h1E1F);

    // Release coinciding with completion of the second frame.
    doReset();
    checkOutput("reset2 overflow", 32'(overflow), 32'd0);
    sendWords(0, 16);
    tick();
    sendWords(64, 16);
    strobeDone();
    checkOutput("coincide frame_bank", 32'(frame_bank), 32'd1);
    checkOutput("coincide frame_ready", 32'(frame_ready), 32'd1);
    checkOutput("coincide overflow", 32'(overflow), 32'd0);
    checkOutput("coincide wr_count", 32'(wr_count), 32'd0);
    readCheck("rd_data coincide a0", 3'd0, 16'h4041);
    sendWords(8'h50, 2);
    tick();
    checkOutput("coincide still FILL", 32'(wr_count), 32'd1);
    strobeDone();
    checkOutput("release drops ready", 32'(frame_ready), 32'd0);
    strobeDone();
    checkOutput("ignored done ready", 32'(frame_ready), 32'd0);
    checkOutput("ignored done bank", 32'(frame_bank), 32'd1);
    sendWords(8'h52, 14);
    tick();
    checkOutput("free swap ready", 32'(frame_ready), 32'd1);
    checkOutput("free swap bank", 32'(frame_bank), 32'd0);
    checkOutput("free swap overflow", 32'(overflow), 32'd0);
    readCheck("rd_data free swap a0", 3'd0, 16'h5051);

    // Reset in the middle of a sample discards the partial word.
    doReset();
    sendWords(8'hA1, 3);
    tick();
    checkOutput("pre-reset wr_count", 32'(wr_count), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("async reset wr_count", 32'(wr_count), 32'd0);
    tick();
    reset = 1'b0;
    sendWords(8'hB1, 2);
    tick();
    checkOutput("post-reset wr_count", 32'(wr_count), 32'd1);
    sendWords(8'hC0, 14);
    tick();
    checkOutput("post-reset ready", 32'(frame_ready), 32'd1);
    checkOutput("post-reset bank", 32'(frame_bank), 32'd0);
    readCheck("rd_data post-reset a0", 3'd0, 16'hB1B2);
    readCheck("rd_data post-reset a1", 3'd1, 16'hC0C1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter SPI_WIDTH, default 8, bits per received SPI word.
REQ-002 Parameter SAMPLE_WIDTH, default 16, bits per stored sample; SHALL be an integer multiple (1..4) of SPI_WIDTH.
REQ-003 Parameter N, default 9, address bits per bank; frame depth = 2^N samples.
REQ-004 The interface SHALL use one clock; reset is asynchronous and active-high.
REQ-005 sclk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 received_wd  input  1  one-cycle strobe: sample_in is valid.
REQ-008 sample_in  input  SPI_WIDTH  SPI word.
REQ-009 rd_en  input  1  read enable, consumer side.
REQ-010 rd_addr  input  N  read address within the bank given by frame_bank.
REQ-011 rd_data  output  SAMPLE_WIDTH  registered read data.
REQ-012 frame_ready  output  1  a full frame is available to the consumer.
REQ-013 frame_bank  output  1  bank index holding the ready frame.
REQ-014 frame_done  input  1  one-cycle strobe: consumer releases the ready frame.
REQ-015 overflow  output  1  sticky: at least one sample was dropped.
REQ-016 wr_count  output  N+1  samples written into the current fill bank.

Function
REQ-017 Words SHALL assemble MSB-first; sample complete after SAMPLE_WIDTH/SPI_WIDTH strobes; a partial sample SHALL persist across idle cycles.
REQ-018 A completed sample SHALL be written in the cycle after its final strobe, at address wr_ptr of fill bank; wr_ptr and wr_count then increment.
REQ-019 Write FSM states: FILL (accepting samples), HOLD (fill bank full, other bank still owned by consumer).
REQ-020 FILL: the write of address 2^N-1 completes the frame; if the other bank is free: frame_ready<=1, frame_bank<=fill bank, fill bank toggles, wr_ptr<=0, wr_count<=0, stay in FILL.
REQ-021 FILL: if the frame completes while frame_ready=1 and no frame_done arrives in that cycle: go to HOLD; completed bank is retained unchanged.
REQ-022 HOLD: completed samples SHALL be dropped and overflow set to 1; on frame_done, perform the REQ-020 swap and return to FILL.
REQ-023 frame_done in the same cycle as frame completion SHALL release first, so the swap proceeds without entering HOLD or setting overflow.
REQ-024 frame_done while frame_ready=0 SHALL be ignored; frame_ready drops the cycle after a valid frame_done unless a swap re-asserts it.
REQ-025 Read latency: rd_data SHALL update one cycle after rd_en=1; holds its value when rd_en=0; reads never target the fill bank.
REQ-026 overflow SHALL clear only on reset.

Reset
REQ-027 On reset: state FILL, fill bank 0, wr_ptr 0, wr_count 0, assembly count 0, frame_ready 0, frame_bank 0, overflow 0, rd_data 0.
REQ-028 Reset asserted mid-frame or mid-sample SHALL discard the partial frame and partial sample; RAM contents are not cleared.

Structure
REQ-029 Package frame_loader_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-030 Word-to-sample packing SHALL be a sub-module sample_assembler (received_wd, sample_in -> sample_valid, sample).
REQ-031 Storage SHALL be one 2^(N+1)-entry dual-port RAM, address = {bank, ptr}.

Verification
REQ-032 N=3, 16 words 0x00..0x0F -> 8 samples 0x0001,0x0203,...,0x0E0F in bank 0; frame_ready=1, frame_bank=0.
REQ-033 Read bank 0 addr 5 -> rd_data=0x0A0B one cycle after rd_en.
REQ-034 Second frame filled with no frame_done -> HOLD, overflow=1, bank 0 data unchanged, third-frame samples dropped.
REQ-035 frame_done strobed on the same cycle the second frame's last sample is written -> frame_bank=1, overflow=0.
REQ-036 reset pulsed after 3 words -> wr_count=0; next 2 words form sample at address 0 of bank 0.
